// File: rtl/ultrasonic_ranger.sv
// HC-SR04 style ranger: periodic trigger, echo pulse timing, distance in cm.
// binary_dist only changes on the dist_valid cycle, so a free-running reader always sees a settled value.
module ultrasonic_ranger #(
  parameter int unsigned TRIG_CYCLES    = 500,
  parameter int unsigned CM_CYCLES      = 2900,
  parameter int unsigned TIMEOUT_CYCLES = 1500000,
  parameter int unsigned PERIOD_CYCLES  = 3000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        echo,
  output logic        trig,
  output logic [11:0] binary_dist,
  output logic        dist_valid,
  output logic        timeout
);

  localparam int unsigned CNT_W  = 22;
  localparam int unsigned DIST_W = 12;
  localparam int unsigned SUB_W  = (CM_CYCLES > 1) ? $clog2(CM_CYCLES) : 1;
  localparam logic [DIST_W-1:0] DIST_MAX = '1;

  typedef enum logic [2:0] {S_WAIT, S_TRIG, S_ARM, S_MEAS, S_DONE} state_t;

  state_t            r_state;
  logic              r_echo_meta;
  logic              r_echo_s;
  logic              r_echo_prev;
  logic [CNT_W-1:0]  r_period;
  logic [CNT_W-1:0]  r_phase;
  logic [SUB_W-1:0]  r_sub;
  logic [DIST_W-1:0] r_cm;
  logic              r_trig;
  logic [DIST_W-1:0] r_dist;
  logic              r_dist_valid;
  logic              r_timeout;
  logic              w_wrap;
  logic              w_rise;

  assign w_wrap = (r_period == CNT_W'(PERIOD_CYCLES - 1));
  assign w_rise = r_echo_s && !r_echo_prev;

  assign trig        = r_trig;
  assign binary_dist = r_dist;
  assign dist_valid  = r_dist_valid;
  assign timeout     = r_timeout;

  // Echo synchronizer plus one-cycle history for rising-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      r_echo_meta <= 1'b0;
      r_echo_s    <= 1'b0;
      r_echo_prev <= 1'b0;
    end else begin
      r_echo_meta <= echo;
      r_echo_s    <= r_echo_meta;
      r_echo_prev <= r_echo_s;
    end
  end

  // Free-running measurement period; runs regardless of FSM state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_period <= '0;
    end else if (w_wrap) begin
      r_period <= '0;
    end else begin
      r_period <= r_period + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_WAIT;
      r_phase      <= '0;
      r_sub        <= '0;
      r_cm         <= '0;
      r_trig       <= 1'b0;
      r_dist       <= DIST_MAX;
      r_dist_valid <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_dist_valid <= 1'b0;
      case (r_state)
        S_WAIT: begin
          r_trig <= 1'b0;
          if (w_wrap) begin
            r_state <= S_TRIG;
            r_trig  <= 1'b1;
            r_phase <= '0;
          end
        end
        S_TRIG: begin
          if (r_phase == CNT_W'(TRIG_CYCLES - 1)) begin
            r_state <= S_ARM;
            r_trig  <= 1'b0;
            r_phase <= '0;
          end else begin
            r_phase <= r_phase + CNT_W'(1);
          end
        end
        S_ARM: begin
          if (w_rise) begin
            // The rising-edge cycle is the first high cycle, so it is counted here
            r_state <= S_MEAS;
            r_cm    <= '0;
            r_sub   <= SUB_W'(1);
            r_phase <= CNT_W'(1);
          end else if (r_phase == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            r_state      <= S_DONE;
            r_dist       <= DIST_MAX;
            r_timeout    <= 1'b1;
            r_dist_valid <= 1'b1;
          end else begin
            r_phase <= r_phase + CNT_W'(1);
          end
        end
        S_MEAS: begin
          if (!r_echo_s) begin
            r_state      <= S_DONE;
            r_dist       <= r_cm;
            r_timeout    <= 1'b0;
            r_dist_valid <= 1'b1;
          end else if (r_phase == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            r_state      <= S_DONE;
            r_dist       <= DIST_MAX;
            r_timeout    <= 1'b1;
            r_dist_valid <= 1'b1;
          end else begin
            r_phase <= r_phase + CNT_W'(1);
            if (r_sub == SUB_W'(CM_CYCLES - 1)) begin
              r_sub <= '0;
              if (r_cm != DIST_MAX) r_cm <= r_cm + DIST_W'(1);
            end else begin
              r_sub <= r_sub + SUB_W'(1);
            end
          end
        end
        S_DONE: begin
          r_state <= S_WAIT;
        end
        default: begin
          r_state <= S_WAIT;
          r_trig  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Directed bench for ultrasonic_ranger using shortened timing parameters.
module tb_ultrasonic_ranger;

  localparam int unsigned TRIG    = 4;
  localparam int unsigned CM      = 10;
  localparam int unsigned TMO     = 300;
  localparam int unsigned PERIOD  = 800;

  logic        clk;
  logic        rst;
  logic        echo;
  logic        trig;
  logic [11:0] binary_dist;
  logic        dist_valid;
  logic        timeout;

  int n_chk = 0;
  int n_err = 0;

  int cyc = 0;
  int dv_cnt = 0;
  int dv_cyc = 0;
  int prev_dv_cyc = 0;
  int glitch_cnt = 0;
  logic [11:0] last_dist = 12'h000;
  logic        last_to = 1'b0;
  logic [11:0] prev_dist = 12'h000;

  int meas_trig_w;
  int meas_fall_cyc;
  int meas_ndv;
  bit meas_ok;

  ultrasonic_ranger #(
    .TRIG_CYCLES   (TRIG),
    .CM_CYCLES     (CM),
    .TIMEOUT_CYCLES(TMO),
    .PERIOD_CYCLES (PERIOD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .echo       (echo),
    .trig       (trig),
    .binary_dist(binary_dist),
    .dist_valid (dist_valid),
    .timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Publication monitor: latches each dist_valid event and counts unannounced dist changes
  always @(negedge clk) begin
    if (dist_valid) begin
      dv_cnt      = dv_cnt + 1;
      last_dist   = binary_dist;
      last_to     = timeout;
      prev_dv_cyc = dv_cyc;
      dv_cyc      = cyc;
    end else if (binary_dist !== prev_dist) begin
      glitch_cnt = glitch_cnt + 1;
    end
    prev_dist = binary_dist;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Wait for the next trigger, measure its width, and note the cycle where it fell
  task automatic wait_trig();
    int guard;
    guard = 0;
    meas_trig_w = 0;
    while (trig !== 1'b1 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    while (trig === 1'b1 && guard < 2000) begin
      meas_trig_w++;
      @(negedge clk);
      guard++;
    end
    meas_fall_cyc = cyc;
    meas_ok = (guard < 2000);
  endtask

  // One full measurement: optional stale-high echo through the trigger, then a clean pulse
  task automatic do_meas(input int dly, input int width, input bit pre_high);
    int start_dv;
    int guard;
    start_dv = dv_cnt;
    if (pre_high) echo = 1'b1;
    wait_trig();
    if (pre_high) begin
      repeat (10) @(negedge clk);
      echo = 1'b0;
    end
    repeat (dly) @(negedge clk);
    echo = 1'b1;
    repeat (width) @(negedge clk);
    echo = 1'b0;
    guard = 0;
    while (dv_cnt == start_dv && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 1000) meas_ok = 1'b0;
    repeat (5) @(negedge clk);
    meas_ndv = dv_cnt - start_dv;
  endtask

  initial begin
    int start_dv;
    int g0;
    rst  = 1'b1;
    echo = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_trig", 32'(trig), 0);
    chk("rst_dist", 32'(binary_dist), 32'hFFF);
    chk("rst_dv", 32'(dist_valid), 0);
    chk("rst_to", 32'(timeout), 0);
    rst = 1'b0;

    // 1: 125-cycle echo -> 12 cm
    do_meas(20, 125, 1'b0);
    chk("t1_ok", 32'(meas_ok), 1);
    chk("t1_trig_w", 32'(meas_trig_w), TRIG);
    chk("t1_ndv", 32'(meas_ndv), 1);
    chk("t1_dist", 32'(last_dist), 12);
    chk("t1_to", 32'(last_to), 0);

    // 2: no echo -> timeout result 300 cycles after trigger falls, then 50 cycles -> 5 cm
    start_dv = dv_cnt;
    wait_trig();
    repeat (320) @(negedge clk);
    chk("t2_ok", 32'(meas_ok), 1);
    chk("t2_ndv", 32'(dv_cnt - start_dv), 1);
    chk("t2_lat", 32'(dv_cyc - meas_fall_cyc), TMO);
    chk("t2_dist", 32'(last_dist), 32'hFFF);
    chk("t2_to", 32'(last_to), 1);
    chk("t2_hold_to", 32'(timeout), 1);
    do_meas(20, 50, 1'b0);
    chk("t2b_ok", 32'(meas_ok), 1);
    chk("t2b_dist", 32'(last_dist), 5);
    chk("t2b_to", 32'(last_to), 0);

    // 3: echo stuck high 400 cycles -> timeout after 300 high cycles, next pulse measured fresh
    do_meas(20, 400, 1'b0);
    chk("t3_ok", 32'(meas_ok), 1);
    chk("t3_ndv", 32'(meas_ndv), 1);
    chk("t3_dist", 32'(last_dist), 32'hFFF);
    chk("t3_to", 32'(last_to), 1);
    do_meas(20, 30, 1'b0);
    chk("t3b_dist", 32'(last_dist), 3);
    chk("t3b_to", 32'(last_to), 0);

    // 4: stale high echo through trigger is ignored; only the fresh 30-cycle pulse counts
    do_meas(20, 30, 1'b1);
    chk("t4_ok", 32'(meas_ok), 1);
    chk("t4_ndv", 32'(meas_ndv), 1);
    chk("t4_dist", 32'(last_dist), 3);
    chk("t4_to", 32'(last_to), 0);

    // Boundary: 299 high cycles is still a valid 29 cm result
    do_meas(20, 299, 1'b0);
    chk("b299_dist", 32'(last_dist), 29);
    chk("b299_to", 32'(last_to), 0);

    // 5: reset in the middle of an echo
    wait_trig();
    repeat (20) @(negedge clk);
    echo = 1'b1;
    repeat (60) @(negedge clk);
    start_dv = dv_cnt;
    rst = 1'b1;
    @(negedge clk);
    chk("t5_trig", 32'(trig), 0);
    chk("t5_dist", 32'(binary_dist), 32'hFFF);
    chk("t5_dv", 32'(dist_valid), 0);
    chk("t5_to", 32'(timeout), 0);
    echo = 1'b0;
    rst  = 1'b0;
    repeat (780) @(negedge clk);
    chk("t5_quiet", 32'(dv_cnt - start_dv), 0);
    do_meas(20, 40, 1'b0);
    chk("t5_ok", 32'(meas_ok), 1);
    chk("t5_ndv", 32'(meas_ndv), 1);
    chk("t5_new_dist", 32'(last_dist), 4);

    // 6: five periods of a constant 70-cycle echo
    g0 = glitch_cnt;
    for (int i = 0; i < 5; i++) begin
      do_meas(20, 70, 1'b0);
      chk($sformatf("t6_ok%0d", i), 32'(meas_ok), 1);
      chk($sformatf("t6_dist%0d", i), 32'(last_dist), 7);
      chk($sformatf("t6_ndv%0d", i), 32'(meas_ndv), 1);
      if (i > 0) chk($sformatf("t6_gap%0d", i), 32'(dv_cyc - prev_dv_cyc), PERIOD);
    end
    chk("t6_glitch", 32'(glitch_cnt - g0), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
